banner_scroll_mux: RTL and testbench
====================================

BANNER_SCROLL_MUX -- requirements
Module: banner_scroll_mux

Interface
REQ-001 Parameter SCROLL_DIV, default 25_000_000: clock cycles per scroll step, at least 2.
REQ-002 Parameter REFRESH_BITS, default 18: refresh counter width; the top 2 bits select the digit slot; at least 3.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port en, input, 1: scroll enable; the display refresh SHALL run regardless of en.
REQ-006 Port dir, input, 1: scroll direction; 0 = forward (pos+1), 1 = reverse (pos-1).
REQ-007 Port msg_load, input, 1: single-cycle strobe that captures msg_data.
REQ-008 Port msg_data, input, 40: ten hex nibbles; nibble i = msg_data[4i+3:4i].
REQ-009 Port dp_en, input, 4: decimal-point request per slot; bit k = slot k.
REQ-010 Port hex, output, 4: nibble to the downstream hex-to-7-segment decoder.
REQ-011 Port dp, output, 1: decimal-point request to the decoder; 1 = point on.
REQ-012 Port an, output, 4: digit anodes, active-low one-hot; an[0] = rightmost slot.
REQ-013 Port pos, output, 4: current scroll position, range 0..9.

Function
REQ-014 The block SHALL hold the message in msg_reg (10 nibbles); msg_load=1 SHALL load msg_data, set pos=0 and clear the scroll prescaler on the same edge.
REQ-015 The scroll prescaler SHALL count 0..SCROLL_DIV-1 only while en=1 and SHALL hold its value while en=0.
REQ-016 A one-cycle tick SHALL fire when the prescaler is at SCROLL_DIV-1 with en=1; the prescaler SHALL then return to 0.
REQ-017 On each tick, pos SHALL step modulo 10: 9->0 when dir=0, 0->9 when dir=1; dir SHALL be sampled in the tick cycle.
REQ-018 If msg_load and tick occur in the same cycle, the load SHALL win and pos SHALL become 0.
REQ-019 The refresh counter SHALL be free-running and wrap at 2^REFRESH_BITS; sel = refresh[REFRESH_BITS-1:REFRESH_BITS-2].
REQ-020 Slot k SHALL display nibble index (pos + 3 - k) mod 10, so slot 3 (leftmost) shows nibble pos.
REQ-021 hex, dp and an SHALL be registered and SHALL reflect the sel, pos and msg_reg values of the previous cycle (1-cycle latency).
REQ-022 The outputs SHALL be driven as follows: an = ~(4'b0001 << sel), dp = dp_en[sel], hex = the nibble for slot sel.
REQ-023 Exactly one an bit SHALL be low at every cycle after the first post-reset cycle.
REQ-024 The index arithmetic SHALL use an explicit mod-10 wrap (a 5-bit sum minus 10 when at least 10); no index SHALL exceed 9.

Reset
REQ-025 While reset_n=0 at a clock edge, the block SHALL set: msg_reg=0, pos=0, prescaler=0, refresh=0, hex=0, dp=0, an=4'b1111 (all off).
REQ-026 Reset SHALL take priority over msg_load and tick; a reset mid-scroll SHALL discard pos and the message.

Structure
REQ-027 A shared package banner_pkg SHALL hold NUM_DIGITS=10, NUM_SLOTS=4, AN_OFF=4'b1111 and the nibble-index width.
REQ-028 The prescaler and tick SHALL be one sub-module, tick_gen (parameter DIV; ports clk, reset_n, en, tick).
REQ-029 The decoder SHALL remain a separate downstream instance; this block SHALL contain no segment encoding.

Verification (SCROLL_DIV=4, REFRESH_BITS=4)
REQ-030 Reset, then load msg_data=40'h9876543210 with en=0 -> pos=0 for 100 cycles; an cycles 1110,1101,1011,0111 every 4 cycles; the slot-3 hex is 0, slot 0 is 3.
REQ-031 en=1, dir=0 -> pos increments every 4 cycles, 0..9 then 0; at pos=8 slots 3..0 show 8,9,0,1.
REQ-032 en=1, dir=1 from pos=0 -> next tick gives pos=9; slots 3..0 show 9,0,1,2.
REQ-033 Pulse msg_load in the same cycle as a tick at pos=5 -> pos=0 and the new message is displayed; the prescaler restarts, so the next tick arrives 4 cycles later.
REQ-034 dp_en=4'b0100 -> dp=1 only while an=1011.
REQ-035 Assert reset_n=0 for one cycle mid-scroll at pos=7 -> next cycle an=1111, hex=0, pos=0, and the message is cleared.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared constants and index helpers for the scrolling hex banner.
package banner_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int NUM_SLOTS  = 4;
  localparam int IDX_W      = 4;
  localparam int SEL_W      = 2;
  localparam int MSG_W      = NUM_DIGITS * 4;

  localparam logic [NUM_SLOTS-1:0] AN_OFF = 4'b1111;

  // Sum of a position and a slot offset never exceeds 12, so one subtraction suffices.
  function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W:0] sum);
    if (sum >= (IDX_W+1)'(NUM_DIGITS)) begin
      return IDX_W'(sum - (IDX_W+1)'(NUM_DIGITS));
    end
    return sum[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] pos_step(input logic [IDX_W-1:0] p,
                                                input logic             rev);
    if (rev) begin
      return (p == '0) ? IDX_W'(NUM_DIGITS - 1) : p - 1'b1;
    end
    return (p >= IDX_W'(NUM_DIGITS - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/banner_scroll_mux_tick_gen.sv
// Scroll prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick on the last count.
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/banner_scroll_mux.sv
// Four-slot window scrolling over a ten-nibble message, time-multiplexed onto one hex decoder.
module banner_scroll_mux
  import banner_pkg::*;
#(
  parameter int SCROLL_DIV   = 25_000_000,
  parameter int REFRESH_BITS = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 msg_load,
  input  logic [MSG_W-1:0]     msg_data,
  input  logic [NUM_SLOTS-1:0] dp_en,
  output logic [3:0]           hex,
  output logic                 dp,
  output logic [NUM_SLOTS-1:0] an,
  output logic [IDX_W-1:0]     pos
);

  logic                    w_tick;
  logic                    w_tg_rst_n;
  logic [SEL_W-1:0]        w_sel;
  logic [IDX_W:0]          w_sum;
  logic [IDX_W-1:0]        w_idx;
  logic [3:0]              w_nib;
  logic [NUM_SLOTS-1:0]    w_an_nxt;

  logic [MSG_W-1:0]        r_msg;
  logic [IDX_W-1:0]        r_pos;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [3:0]              r_hex;
  logic                    r_dp;
  logic [NUM_SLOTS-1:0]    r_an;

  // A load restarts the prescaler on the same edge through its synchronous reset.
  assign w_tg_rst_n = reset_n & ~msg_load;

  tick_gen #(
    .DIV (SCROLL_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (w_tg_rst_n),
    .en      (en),
    .tick    (w_tick)
  );

  // Stage 0: message/position state and slot-to-nibble mapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_msg <= '0;
      r_pos <= '0;
    end else if (msg_load) begin
      r_msg <= msg_data;
      r_pos <= '0;
    end else if (w_tick) begin
      r_pos <= pos_step(r_pos, dir);
    end
  end

  assign w_sel    = r_refresh[REFRESH_BITS-1 -: SEL_W];
  assign w_sum    = {1'b0, r_pos} + (IDX_W+1)'(NUM_SLOTS - 1)
                  - {{(IDX_W+1-SEL_W){1'b0}}, w_sel};
  assign w_idx    = idx_wrap(w_sum);
  assign w_nib    = r_msg[{w_idx, 2'b00} +: 4];
  assign w_an_nxt = ~(NUM_SLOTS'(1) << w_sel);

  // Stage 1: registered drive to the decoder and anodes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_refresh <= '0;
      r_hex     <= '0;
      r_dp      <= 1'b0;
      r_an      <= AN_OFF;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      r_hex     <= w_nib;
      r_dp      <= dp_en[w_sel];
      r_an      <= w_an_nxt;
    end
  end

  assign hex = r_hex;
  assign dp  = r_dp;
  assign an  = r_an;
  assign pos = r_pos;

endmodule

// File: tb/tb_banner_scroll_mux.sv
// Directed scoreboard bench for banner_scroll_mux with a small behavioural reference model.
module tb_banner_scroll_mux;

  localparam int DIV = 4;
  localparam int RB  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic        msg_load = 1'b0;
  logic [39:0] msg_data = '0;
  logic [3:0]  dp_en = '0;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic [3:0]  pos;

  typedef struct packed {
    logic [3:0] hex;
    logic       dp;
    logic [3:0] an;
    logic [3:0] pos;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [39:0] m_msg = '0;
  int          m_pos = 0;
  int          m_pre = 0;
  int          m_ref = 0;

  banner_scroll_mux #(
    .SCROLL_DIV   (DIV),
    .REFRESH_BITS (RB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .dir      (dir),
    .msg_load (msg_load),
    .msg_data (msg_data),
    .dp_en    (dp_en),
    .hex      (hex),
    .dp       (dp),
    .an       (an),
    .pos      (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the registered outputs from the model, advance it, then compare.
  task automatic cyc();
    exp_t e;
    int   sel;
    int   idx;
    bit   tick;
    if (!reset_n) begin
      e.hex = 4'h0;
      e.dp  = 1'b0;
      e.an  = 4'b1111;
      m_msg = '0;
      m_pos = 0;
      m_pre = 0;
      m_ref = 0;
    end else begin
      sel   = m_ref >> (RB - 2);
      idx   = (m_pos + 3 - sel) % 10;
      e.hex = 4'((m_msg >> (4 * idx)) & 40'hF);
      e.dp  = dp_en[sel];
      e.an  = 4'(4'hF ^ (1 << sel));
      tick  = en && (m_pre == DIV - 1);
      if (msg_load) begin
        m_msg = msg_data;
        m_pos = 0;
        m_pre = 0;
      end else begin
        if (en) m_pre = (m_pre == DIV - 1) ? 0 : m_pre + 1;
        if (tick) m_pos = dir ? (m_pos + 9) % 10 : (m_pos + 1) % 10;
      end
      m_ref = (m_ref + 1) % (1 << RB);
    end
    e.pos = 4'(m_pos);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("hex", 32'(hex), 32'(e.hex));
    chk("dp",  32'(dp),  32'(e.dp));
    chk("an",  32'(an),  32'(e.an));
    chk("pos", 32'(pos), 32'(e.pos));
  endtask

  task automatic wait_pos(input int target, input int max_cyc);
    int n = 0;
    while (pos !== 4'(target) && n < max_cyc) begin
      cyc();
      n++;
    end
    chk("wait_pos", 32'(pos), 32'(target));
  endtask

  // With position frozen, capture the nibble shown in each slot over one refresh period.
  task automatic check_slots(input logic [3:0] e3, input logic [3:0] e2,
                             input logic [3:0] e1, input logic [3:0] e0);
    logic [3:0] cap [4];
    for (int k = 0; k < 4; k++) cap[k] = 4'bxxxx;
    repeat (16) begin
      cyc();
      for (int k = 0; k < 4; k++) begin
        if (an === 4'(~(4'b0001 << k))) cap[k] = hex;
      end
    end
    chk("slot3", 32'(cap[3]), 32'(e3));
    chk("slot2", 32'(cap[2]), 32'(e2));
    chk("slot1", 32'(cap[1]), 32'(e1));
    chk("slot0", 32'(cap[0]), 32'(e0));
  endtask

  initial begin
    int n;

    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_an",  32'(an),  32'h0000000F);
    chk("rst_hex", 32'(hex), 32'h0);
    chk("rst_pos", 32'(pos), 32'h0);

    reset_n  = 1'b1;
    msg_load = 1'b1;
    msg_data = 40'h9876543210;
    cyc();
    msg_load = 1'b0;
    repeat (100) begin
      cyc();
      chk("hold_pos", 32'(pos), 32'h0);
      if (an === 4'b0111) chk("hold_slot3", 32'(hex), 32'h0);
      if (an === 4'b1110) chk("hold_slot0", 32'(hex), 32'h3);
    end

    en  = 1'b1;
    dir = 1'b0;
    wait_pos(8, 60);
    en = 1'b0;
    check_slots(4'h8, 4'h9, 4'h0, 4'h1);

    en = 1'b1;
    wait_pos(0, 40);
    dir = 1'b1;
    wait_pos(9, 10);
    en = 1'b0;
    check_slots(4'h9, 4'h0, 4'h1, 4'h2);

    en  = 1'b1;
    dir = 1'b0;
    wait_pos(5, 80);
    while (m_pre != DIV - 1) cyc();
    msg_load = 1'b1;
    msg_data = 40'h0123456789;
    cyc();
    msg_load = 1'b0;
    chk("load_pos", 32'(pos), 32'h0);
    n = 0;
    while (pos === 4'd0 && n < 10) begin
      cyc();
      n++;
    end
    chk("restart_gap", 32'(n), 32'd4);
    en = 1'b0;
    check_slots(4'h8, 4'h7, 4'h6, 4'h5);

    dp_en = 4'b0100;
    repeat (16) begin
      cyc();
      chk("dp_slot2", 32'(dp), 32'(an === 4'b1011));
    end
    dp_en = 4'b0000;

    en = 1'b1;
    wait_pos(7, 40);
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_an",  32'(an),  32'h0000000F);
    chk("mid_rst_hex", 32'(hex), 32'h0);
    chk("mid_rst_pos", 32'(pos), 32'h0);
    reset_n = 1'b1;
    en      = 1'b0;
    check_slots(4'h0, 4'h0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
